kernel_pipe_driver: RTL
=======================

KERNEL_PIPE_DRIVER -- requirements
Module: kernel_pipe_driver

Interface
REQ-001 The block SHALL have parameter DATAW, default 32, giving the data width of the stream and kernel ports.
REQ-002 The block SHALL have parameter KLAT, default 3, giving the kernel pipeline latency in non-stalled cycles (legal range 1..16).
REQ-003 The block SHALL have parameter FDEPTH, default 8, giving the output FIFO depth (power of 2, at least 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have ports in_valid (input, 1), in_data (input, DATAW), in_last (input, 1) and in_ready (output, 1): the upstream channel.
REQ-007 The block SHALL have ports out_valid (output, 1), out_data (output, DATAW) and out_ready (input, 1): the downstream channel.
REQ-008 The block SHALL have ports stall (output, 1), kd_vin (output, DATAW) and kd_vout (input, DATAW): the kernel-side stall pipeline.
REQ-009 The block SHALL have ports done (output, 1), a one-cycle completion pulse, and count_out (output, 16), the number of words delivered downstream.

Function
REQ-010 in_ready SHALL equal !stall whenever the FSM is IDLE or RUN, and SHALL be 0 in DRAIN and DONE.
REQ-011 kd_vin SHALL equal in_data combinationally.
REQ-012 An input word SHALL be accepted in a cycle where in_valid && in_ready.
REQ-013 The block SHALL keep a KLAT-stage valid shift register vsr.
  - vsr shifts only when stall=0.
  - vsr[0] loads the accept condition of REQ-012.
REQ-014 When vsr[KLAT-1]=1, kd_vout SHALL be treated as a valid result and pushed into the output FIFO in any cycle where stall=0.
REQ-015 stall SHALL equal vsr[KLAT-1] && fifo_full && !(out_valid && out_ready).
  - This path is combinational.
  - A simultaneous pop makes room, so no stall occurs in that case.
REQ-016 While stall=1, no vsr entry, FIFO entry or kernel result SHALL be lost or duplicated.
REQ-017 out_valid SHALL equal !fifo_empty and out_data SHALL equal the FIFO head; both are registered outputs of the FIFO.
REQ-018 A push and a pop in the same cycle SHALL leave the occupancy unchanged, including when the FIFO is full.
REQ-019 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
  - IDLE to RUN on the first accept.
  - RUN to DRAIN on an accept with in_last=1; an accept with in_last=1 in IDLE goes directly to DRAIN.
  - DRAIN to DONE when vsr is all zero and the FIFO is empty.
  - DONE to IDLE unconditionally after one cycle.
REQ-020 done SHALL be 1 exactly while the FSM is in DONE.
REQ-021 count_out SHALL increment on each out_valid && out_ready, SHALL wrap from 0xFFFF to 0, and SHALL clear on the IDLE-to-RUN or IDLE-to-DRAIN transition.
REQ-022 Minimum latency from accept to out_valid SHALL be KLAT+1 cycles with out_ready held at 1.
REQ-023 Sustained throughput SHALL be one word per cycle while out_ready=1.

Reset
REQ-024 While rst=0 at a clock edge, the block SHALL:
  - set the FSM to IDLE;
  - clear vsr and the FIFO;
  - set count_out=0.
REQ-025 In the cycle after reset, outputs SHALL be stall=0, out_valid=0, done=0 and in_ready=1.
REQ-026 A reset asserted mid-operation SHALL discard all in-flight and buffered words, with no done pulse.

Structure
REQ-027 FIFO pointer-width and counter-width constants SHALL live in the team's shared kernel include header.
REQ-028 The output buffer SHALL be a separate synchronous FIFO sub-module named kernel_pipe_fifo, with push, pop, full, empty and a count output.
REQ-029 The FSM, vsr, stall logic and count_out SHALL reside in kernel_pipe_driver.

Verification (KLAT=3, FDEPTH=4, identity kernel model honouring stall)
REQ-030 The bench SHALL cover a streaming run: in_valid=1, data 1..10, in_last on 10, out_ready=1. Required: out_data 1..10 in order, first out_valid 4 cycles after the first accept, done pulses once, count_out=10.
REQ-031 The bench SHALL cover a backpressure run: out_ready=0 while feeding 8 words. Required: FIFO fills to 4, stall rises when vsr[2]=1, in_ready=0 thereafter. Releasing out_ready then delivers all 8 words in order, none lost.
REQ-032 The bench SHALL cover a simultaneous push/pop at full FIFO with out_ready=1. Required: stall stays 0 and occupancy stays 4.
REQ-033 The bench SHALL cover a single word with in_last=1 from IDLE. Required: FSM goes to DRAIN, word delivered, done pulses, FSM returns to IDLE.
REQ-034 The bench SHALL cover a reset mid-stream with 3 words in the pipe and 2 in the FIFO. Required: after reset, out_valid=0, count_out=0, no done pulse, and a new stream of data 0xA, 0xB emerges exactly once each.

Source files
------------

// File: rtl/kernel_pipe_driver_pkg.sv
// Shared constants and types for the kernel pipe driver slice.
//   CNTW       : width of the delivered-word counter (count_out)
//   state_t    : driver control states
//   ptr_width  : FIFO pointer width for a given power-of-two depth
package kernel_pipe_driver_pkg;

    localparam int CNTW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A depth-2 FIFO still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/kernel_pipe_fifo.sv
// Synchronous show-ahead FIFO with registered head and status.
//   clk, rst      : clock, synchronous active-low reset
//   push/push_data: write request and data (ignored when full unless popping)
//   pop           : read request (ignored when empty)
//   head          : registered copy of the oldest entry
//   full, empty   : registered status flags
//   count         : current occupancy (0..FDEPTH)
module kernel_pipe_fifo
    import kernel_pipe_driver_pkg::*;
#(
    parameter int DATAW  = 32,
    parameter int FDEPTH = 8,
    localparam int PTRW  = ptr_width(FDEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DATAW-1:0] push_data,
    input  logic             pop,
    output logic [DATAW-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [PTRW:0]    count
);

    logic [DATAW-1:0] mem [FDEPTH];
    logic [PTRW-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [PTRW:0]    count_reg, count_next;
    logic             full_reg, empty_reg;
    logic [DATAW-1:0] head_reg;
    logic             do_push, do_pop;

    always_comb begin
        do_pop      = pop && !empty_reg;
        // A push into a full FIFO is legal only when the same cycle frees a slot.
        do_push     = push && (!full_reg || do_pop);
        rd_ptr_next = do_pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        count_next  = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Registered read of the next head; bypass when the slot being written
    // is the one that becomes the head (empty FIFO or single-entry turnover).
    always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= push_data;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= (count_next == (PTRW+1)'(FDEPTH));
            empty_reg  <= (count_next == '0);
        end
    end

    assign head  = head_reg;
    assign full  = full_reg;
    assign empty = empty_reg;
    assign count = count_reg;

endmodule

// File: rtl/kernel_pipe_driver.sv
// Drives a fixed-latency stallable kernel pipeline and buffers its results.
//   clk, rst                         : clock, synchronous active-low reset
//   in_valid/in_data/in_last/in_ready: upstream stream
//   out_valid/out_data/out_ready     : downstream stream (from output FIFO)
//   stall                            : freezes the kernel pipeline
//   kd_vin / kd_vout                 : kernel input / kernel result
//   done                             : one-cycle pulse when a stream has drained
//   count_out                        : words delivered in the current stream
module kernel_pipe_driver
    import kernel_pipe_driver_pkg::*;
#(
    parameter int DATAW  = 32,
    parameter int KLAT   = 3,
    parameter int FDEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    input  logic             out_ready,
    output logic             stall,
    output logic [DATAW-1:0] kd_vin,
    input  logic [DATAW-1:0] kd_vout,
    output logic             done,
    output logic [CNTW-1:0]  count_out
);

    localparam int PTRW = ptr_width(FDEPTH);

    state_t          state_reg, state_next;
    logic [KLAT-1:0] vsr_reg, vsr_next;
    logic [CNTW-1:0] count_reg, count_next;
    logic            accept, pop, push;
    logic            fifo_full, fifo_empty;
    logic [PTRW:0]   fifo_count;

    assign kd_vin    = in_data;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    // Only a result leaving the pipe into a full FIFO with no pop this cycle
    // has nowhere to go; everything else keeps moving.
    assign stall     = vsr_reg[KLAT-1] && fifo_full && !pop;
    assign push      = vsr_reg[KLAT-1] && !stall;
    assign count_out = count_reg;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        done       = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                in_ready = !stall;
                if (in_valid && in_ready) begin
                    state_next = in_last ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = !stall;
                if (in_valid && in_ready && in_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((vsr_reg == '0) && (fifo_count == '0)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        accept = in_valid && in_ready;

        vsr_next = vsr_reg;
        if (!stall) begin
            vsr_next    = vsr_reg << 1;
            vsr_next[0] = accept;
        end

        count_next = count_reg;
        if ((state_reg == ST_IDLE) && accept) begin
            count_next = '0;
        end else if (pop) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            vsr_reg   <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            vsr_reg   <= vsr_next;
            count_reg <= count_next;
        end
    end

    kernel_pipe_fifo #(
        .DATAW  (DATAW),
        .FDEPTH (FDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (kd_vout),
        .pop       (pop),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
